// File: rtl/weight_pattern_gen_pkg.sv
// Shared definitions for the weight pattern generator: FSM encoding,
// default word width and the derived weight/index widths.
package weight_pattern_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_FIN  = 2'd2
    } wpg_state_e;

    localparam int unsigned WPG_W_DEFAULT = 8;

    // Width needed to hold a weight in 0..w.
    function automatic int unsigned wpg_kw(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    // Width of the sequence index; C(w, w/2) < 2**w for every supported w.
    function automatic int unsigned wpg_cw(input int unsigned w);
        return w;
    endfunction

endpackage

// File: rtl/weight_pattern_gen_next.sv
// next_weight_word: combinational Gosper successor of a W-bit word with
// fixed popcount, plus a flag telling whether that successor is the final
// (highest) word of weight k.
//   x         : current word
//   k         : target weight
//   next_word : next larger word with the same popcount as x
//   is_last   : next_word equals k ones packed at the top of the word
module next_weight_word #(
    parameter int unsigned W  = 8,
    parameter int unsigned KW = $clog2(W + 1)
) (
    input  logic [W-1:0]  x,
    input  logic [KW-1:0] k,
    output logic [W-1:0]  next_word,
    output logic          is_last
);

    localparam int unsigned XW   = W + 1;
    localparam int unsigned CTZW = $clog2(W);

    logic [XW-1:0]   x_ext;
    logic [XW-1:0]   low_bit;
    logic [XW-1:0]   ripple;
    logic [CTZW-1:0] ctz;
    logic [W-1:0]    last_pat;

    // Isolate lowest set bit, locate it, then ripple and refill the low ones.
    always_comb begin
        x_ext   = {1'b0, x};
        low_bit = x_ext & (~x_ext + XW'(1));
        ctz     = '0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (low_bit[i]) begin
                ctz = CTZW'(i);
            end
        end
        ripple    = x_ext + low_bit;
        next_word = W'((((ripple ^ x_ext) >> 2) >> ctz) | ripple);
    end

    // Final word of weight k: ones in bit positions W-k .. W-1.
    always_comb begin
        for (int i = 0; i < int'(W); i++) begin
            last_pat[i] = (i >= int'(W) - int'(k));
        end
        is_last = (next_word == last_pat);
    end

endmodule

// File: rtl/weight_pattern_gen.sv
// weight_pattern_gen: enumerates every W-bit word with exactly `weight` ones
// in ascending order over a valid/ready stream.
//   start/weight : launch an enumeration (accepted only while idle)
//   abort        : terminate an enumeration in progress
//   busy         : high whenever not idle
//   out_*        : valid/ready word stream with index and last flag
//   done         : one-cycle pulse after the final transfer or an abort
//   err          : one-cycle pulse when start carries weight > W
module weight_pattern_gen
    import weight_pattern_gen_pkg::*;
#(
    parameter int unsigned W  = WPG_W_DEFAULT,
    parameter int unsigned KW = wpg_kw(W),
    parameter int unsigned CW = wpg_cw(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] weight,
    input  logic          abort,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_word,
    output logic [CW-1:0] out_idx,
    output logic          out_last,
    output logic          done,
    output logic          err
);

    wpg_state_e    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  word_q, word_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [W-1:0]  first_word_c;
    logic [W-1:0]  succ_word;
    logic          succ_last;

    next_weight_word #(
        .W  (W),
        .KW (KW)
    ) u_next (
        .x         (word_q),
        .k         (k_q),
        .next_word (succ_word),
        .is_last   (succ_last)
    );

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        // Lowest word of the requested weight: k ones at the bottom.
        for (int i = 0; i < int'(W); i++) begin
            first_word_c[i] = (i < int'(weight));
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (32'(weight) > 32'(W)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_EMIT;
                        k_d     = weight;
                        word_d  = first_word_c;
                        idx_d   = '0;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        // Only k=0 and k=W have a single-word sequence.
                        last_d  = (weight == '0) || (32'(weight) == 32'(W));
                    end
                end
            end
            ST_EMIT: begin
                if (abort) begin
                    state_d = ST_FIN;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (valid_q && out_ready) begin
                    if (last_q) begin
                        state_d = ST_FIN;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        word_d = succ_word;
                        idx_d  = idx_q + CW'(1);
                        last_d = succ_last;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_word  = word_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Scoreboard bench for weight_pattern_gen: the reference model enumerates
// all W-bit values, keeps those of popcount k, and queues them in order.
module tb_weight_pattern_gen;

    localparam int unsigned W  = 8;
    localparam int unsigned KW = 4;
    localparam int unsigned CW = 8;

    typedef struct packed {
        logic [W-1:0]  word;
        logic [CW-1:0] idx;
        logic          last;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [KW-1:0] weight;
    logic          abort;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_word;
    logic [CW-1:0] out_idx;
    logic          out_last;
    logic          done;
    logic          err;

    exp_t exp_q[$];
    int   n_vec        = 0;
    int   n_fail       = 0;
    int   cyc          = 0;
    int   exp_done_cyc = -1;
    int   cur_k        = 0;
    int   xfers        = 0;
    bit   stall_en     = 1'b0;

    bit            hold_chk = 1'b0;
    logic [W-1:0]  held_word;
    logic [CW-1:0] held_idx;
    logic          held_last;

    weight_pattern_gen #(.W(W), .KW(KW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .weight    (weight),
        .abort     (abort),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int choose(input int n, input int k);
        longint r = 1;
        for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
        return int'(r);
    endfunction

    // Reference model: brute-force scan of all W-bit values.
    function automatic void push_expected(input int k);
        logic [W-1:0] words[$];
        logic [W-1:0] v;
        exp_t e;
        for (int i = 0; i < (1 << W); i++) begin
            v = W'(i);
            if ($countones(v) == k) words.push_back(v);
        end
        for (int i = 0; i < words.size(); i++) begin
            e.word = words[i];
            e.idx  = CW'(i);
            e.last = (i == words.size() - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Consumer: random back-pressure when enabled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Monitor: compare each transfer against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) chk("popcount", $countones(out_word), cur_k);
        if (hold_chk && out_valid) begin
            chk("stall_word", out_word, held_word);
            chk("stall_idx", out_idx, held_idx);
            chk("stall_last", out_last, held_last);
        end
        hold_chk  = out_valid && !out_ready && !abort;
        held_word = out_word;
        held_idx  = out_idx;
        held_last = out_last;
        if (out_valid && abort) begin
            exp_q.delete();
            exp_done_cyc = cyc + 2;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", out_word, 0);
                n_fail += (out_word == 0) ? 1 : 0;
            end else begin
                e = exp_q.pop_front();
                chk("word", out_word, e.word);
                chk("idx", out_idx, e.idx);
                chk("last", out_last, e.last);
            end
            xfers++;
            if (out_last) exp_done_cyc = cyc + 2;
        end
        if (done) begin
            chk("done_timing", cyc, exp_done_cyc);
            exp_done_cyc = -1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input int k);
        start  = 1'b1;
        weight = KW'(k);
        cur_k  = k;
        xfers  = 0;
        if (k <= int'(W)) push_expected(k);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk({name, "_busy_low"}, busy, 0);
            end
        end
        chk({name, "_done_seen"}, seen, 1);
        tick();
    endtask

    task automatic run_full(input int k, input string name);
        issue_start(k);
        wait_done(name, 600);
        chk({name, "_length"}, xfers, choose(int'(W), k));
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        bit reached;
        rst_n  = 1'b0;
        start  = 1'b0;
        weight = '0;
        abort  = 1'b0;
        #23;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_word", out_word, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_full(3, "k3");
        run_full(0, "k0");
        run_full(8, "k8");

        // Illegal weight
        issue_start(9);
        @(negedge clk);
        chk("k9_err", err, 1);
        chk("k9_valid", out_valid, 0);
        chk("k9_busy", busy, 0);
        tick();
        @(negedge clk);
        chk("k9_err_pulse", err, 0);
        chk("k9_valid_after", out_valid, 0);
        tick();
        run_full(1, "k1");

        // Back-pressure
        stall_en = 1'b1;
        run_full(4, "k4_stall");
        stall_en = 1'b0;
        tick();

        // Abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_done", done, 0);
        tick();

        // Abort after 5 transfers, with a stray start mid-run
        issue_start(2);
        start  = 1'b1;
        weight = KW'(7);
        tick();
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            if (xfers >= 5) reached = 1'b1;
            else tick();
        end
        chk("abort_reach5", reached, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_valid_drop", out_valid, 0);
        chk("abort_busy_fin", busy, 1);
        wait_done("abort", 10);
        chk("abort_xfers", xfers, 5);
        run_full(2, "k2_restart");

        // Asynchronous reset mid-stream
        issue_start(5);
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            if (out_valid && out_idx == CW'(10)) reached = 1'b1;
            else tick();
        end
        chk("rst_reach10", reached, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_word", out_word, 0);
        chk("arst_idx", out_idx, 0);
        chk("arst_last", out_last, 0);
        exp_q.delete();
        exp_done_cyc = -1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_full(5, "k5_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
